prog_run_ctrl: RTL and testbench
================================

// Module: prog_run_ctrl
// PURPOSE
//  Run-sequencer for the X9 core: turns a level req/done handshake into a controlled program run.
//  Holds the core (PC, flags, reg file) in reset while idle and pulses a clean reset before each run.
//  Enables execution, counts run cycles and stops on halt, end-of-program PC or a cycle-limit timeout.
//  Drains in-flight stores before raising done. Sits between the testbench/top-level req/done pins and the core.
// PARAMETERS
//  D         12        program counter width; matches the PC
//  CW        16        cycle counter width
//  MAX_CYC   16'hFFF0  run-cycle limit before timeout; 1 <= MAX_CYC <= 2**CW-1
//  END_PC    2**D-1    PC value that terminates a run
//  DRAIN     2         core-stalled cycles between run end and done; 1 <= DRAIN <= 15
// PORTS
//  clk        in   1      single clock; all state changes on posedge
//  reset      in   1      synchronous, active-high
//  req        in   1      run request, level; start is qualified by a 0->1 transition
//  prog_ctr   in   D      current PC from the core
//  halt_i     in   1      decoder flag: the instruction in this cycle is a halt
//  core_reset out  1      drives the core's reset; 1 = core held in reset
//  core_en    out  1      core execute enable; 0 = PC and all writes frozen
//  busy       out  1      1 in CLR, RUN and DRN
//  done       out  1      run finished; held until req is seen low
//  timeout    out  1      run ended by the cycle limit; valid while done=1
//  cyc_cnt    out  CW     RUN cycles of the last/current run
// BEHAVIOUR
//  All outputs are registered (Moore); there is no combinational path from any input to any output.
//  States: IDLE, CLR, RUN, DRN (drain), FIN.
//  Reset (sync, any state, including mid-run) -> IDLE with:
//   core_reset=1, core_en=0, busy=0, done=0, timeout=0, cyc_cnt=0, req_q=0.
//  req_q registers req every cycle. start = req & ~req_q.
//  IDLE:
//   core_reset=1, core_en=0.
//   start -> CLR.
//  CLR (exactly 1 cycle):
//   core_reset=1, core_en=0, busy=1; cyc_cnt cleared to 0, timeout cleared to 0.
//   Always -> RUN.
//   Latency: req rises before edge t -> CLR after t -> first RUN cycle after t+1.
//  RUN:
//   core_reset=0, core_en=1, busy=1.
//   cyc_cnt += 1 on every RUN edge, including the exiting edge.
//   Exit on the first edge where any of these holds:
//    halt_i=1, or prog_ctr==END_PC  -> DRN, timeout stays 0
//    cyc_cnt==MAX_CYC-1             -> DRN, timeout<=1
//   Priority: halt/END_PC beat timeout when they coincide (timeout=0).
//   Halt in RUN cycle k gives final cyc_cnt=k. Timeout gives final cyc_cnt=MAX_CYC.
//   req dropping or re-rising during RUN is ignored; the run always completes.
//  DRN:
//   core_reset=0, core_en=0, busy=1. Internal drain counter loads DRAIN-1 on entry.
//   Counter==0 -> FIN; exactly DRAIN cycles are spent in DRN.
//  FIN:
//   done=1, busy=0, core_en=0, core_reset=1. cyc_cnt and timeout held.
//   req_q==0 -> IDLE, where done returns to 0.
//   req held high never restarts; a new run needs req low then high.
//   A req rise in the same cycle FIN exits counts as a start, so IDLE->CLR follows next edge.
//  cyc_cnt never wraps. MAX_CYC <= 2**CW-1 is an elaboration check ($error).
// TESTING
//  1. Reset mid-run: reset=1 during RUN cycle 5 -> next edge IDLE, core_reset=1, done=0, cyc_cnt=0.
//  2. Basic run: reset, req 0->1, halt_i=1 in RUN cycle 7 -> cyc_cnt=7, timeout=0; DRN 2 cycles; done=1 at RUN_end+2.
//  3. Timeout: MAX_CYC=20, halt never -> exactly 20 RUN cycles with core_en=1; timeout=1, cyc_cnt=20, done=1.
//  4. Coincidence: MAX_CYC=10, halt_i=1 in RUN cycle 10 -> timeout=0, cyc_cnt=10.
//     Also prog_ctr==END_PC in cycle 3 -> exit, cyc_cnt=3.
//  5. Handshake: req held high after done -> stays in FIN. req low 1 cycle -> IDLE.
//     req high again -> CLR, cyc_cnt reset to 0, second run executes.
//  6. Glitches: req pulsed low/high during RUN -> no restart, cyc_cnt monotonic.
//     core_reset=1 exactly in CLR/IDLE/FIN, checked by assertion.

Source files
------------

// File: rtl/prog_run_ctrl.sv
// Run sequencer for the X9 core.
// Converts a level req/done handshake into one controlled program run:
// the core is held in reset while idle, gets a one-cycle clean reset (CLR),
// executes while run cycles are counted (RUN), drains in-flight stores with
// execution frozen (DRN), then reports done until req is seen low (FIN).
// Every output comes straight from a flop, so no input reaches an output
// combinationally.
module prog_run_ctrl #(
    parameter int unsigned D       = 12,
    parameter int unsigned CW      = 16,
    parameter int unsigned MAX_CYC = 16'hFFF0,
    parameter int unsigned END_PC  = (1 << D) - 1,
    parameter int unsigned DRAIN   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [D-1:0]  prog_ctr,
    input  logic          halt_i,
    output logic          core_reset,
    output logic          core_en,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cyc_cnt
);

    // Elaboration-time parameter sanity: the cycle counter must be able to
    // hold MAX_CYC, and the drain counter is four bits wide.
    generate
        if ((MAX_CYC < 1) || (64'(MAX_CYC) > ((64'(1) << CW) - 64'(1)))) begin : g_bad_max_cyc
            $error("prog_run_ctrl: MAX_CYC must satisfy 1 <= MAX_CYC <= 2**CW-1");
        end
        if ((DRAIN < 1) || (DRAIN > 15)) begin : g_bad_drain
            $error("prog_run_ctrl: DRAIN must satisfy 1 <= DRAIN <= 15");
        end
    endgenerate

    localparam logic [D-1:0]  END_PC_V = D'(END_PC);
    localparam logic [CW-1:0] LIMIT_V  = CW'(MAX_CYC - 1);
    localparam logic [3:0]    DRN_LOAD = 4'(DRAIN - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_RUN  = 3'd2,
        ST_DRN  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic          req_q_reg;
    logic          pend_reg, pend_next;
    logic [3:0]    drn_cnt_reg, drn_cnt_next;
    logic [CW-1:0] cyc_cnt_reg, cyc_cnt_next;
    logic          timeout_reg, timeout_next;
    logic          core_reset_reg, core_reset_next;
    logic          core_en_reg, core_en_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic start;
    logic stop_hit;
    logic limit_hit;

    // A start is a rising edge of req; the edge detector runs in every state.
    assign start     = req & ~req_q_reg;
    assign stop_hit  = halt_i | (prog_ctr == END_PC_V);
    assign limit_hit = (cyc_cnt_reg == LIMIT_V);

    // State register: FSM state, counters, req history and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            req_q_reg      <= 1'b0;
            pend_reg       <= 1'b0;
            drn_cnt_reg    <= 4'd0;
            cyc_cnt_reg    <= '0;
            timeout_reg    <= 1'b0;
            core_reset_reg <= 1'b1;
            core_en_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            req_q_reg      <= req;
            pend_reg       <= pend_next;
            drn_cnt_reg    <= drn_cnt_next;
            cyc_cnt_reg    <= cyc_cnt_next;
            timeout_reg    <= timeout_next;
            core_reset_reg <= core_reset_next;
            core_en_reg    <= core_en_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    // Next-state logic: sequencing, run-cycle counting and exit priority.
    always_comb begin
        state_next   = state_reg;
        pend_next    = 1'b0;
        drn_cnt_next = drn_cnt_reg;
        cyc_cnt_next = cyc_cnt_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            ST_IDLE: begin
                // pend_reg carries a req rise that arrived on the FIN exit edge
                if (start || pend_reg) begin
                    state_next   = ST_CLR;
                    cyc_cnt_next = '0;
                    timeout_next = 1'b0;
                end
            end
            ST_CLR: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                // counted on every RUN edge, the exiting one included
                cyc_cnt_next = cyc_cnt_reg + 1'b1;
                if (stop_hit) begin
                    // halt / end-of-program wins over a coinciding limit
                    state_next   = ST_DRN;
                    drn_cnt_next = DRN_LOAD;
                end else if (limit_hit) begin
                    state_next   = ST_DRN;
                    drn_cnt_next = DRN_LOAD;
                    timeout_next = 1'b1;
                end
            end
            ST_DRN: begin
                if (drn_cnt_reg == 4'd0) begin
                    state_next = ST_FIN;
                end else begin
                    drn_cnt_next = drn_cnt_reg - 4'd1;
                end
            end
            ST_FIN: begin
                if (!req_q_reg) begin
                    state_next = ST_IDLE;
                    pend_next  = start;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so outputs land in flops.
    always_comb begin
        core_reset_next = 1'b1;
        core_en_next    = 1'b0;
        busy_next       = 1'b0;
        done_next       = 1'b0;
        case (state_next)
            ST_CLR: begin
                busy_next = 1'b1;
            end
            ST_RUN: begin
                core_reset_next = 1'b0;
                core_en_next    = 1'b1;
                busy_next       = 1'b1;
            end
            ST_DRN: begin
                core_reset_next = 1'b0;
                busy_next       = 1'b1;
            end
            ST_FIN: begin
                done_next = 1'b1;
            end
            default: begin
                core_reset_next = 1'b1;
            end
        endcase
    end

    assign core_reset = core_reset_reg;
    assign core_en    = core_en_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign timeout    = timeout_reg;
    assign cyc_cnt    = cyc_cnt_reg;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Self-checking bench for prog_run_ctrl.
// Each run is predicted as a timeline: one CLR cycle, N RUN cycles, DRAIN
// drain cycles, then FIN, where N is the earliest of the halt cycle, the
// END_PC cycle and the cycle limit.
module tb_prog_run_ctrl;

    localparam int D     = 12;
    localparam int CW    = 16;
    localparam int MAXC  = 20;
    localparam int ENDPC = (1 << D) - 1;
    localparam int DRAIN = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic [D-1:0]  prog_ctr;
    logic          halt_i;
    logic          core_reset;
    logic          core_en;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cyc_cnt;

    int checks = 0;
    int errors = 0;

    prog_run_ctrl #(
        .D       (D),
        .CW      (CW),
        .MAX_CYC (MAXC),
        .END_PC  (ENDPC),
        .DRAIN   (DRAIN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .prog_ctr   (prog_ctr),
        .halt_i     (halt_i),
        .core_reset (core_reset),
        .core_en    (core_en),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cyc_cnt    (cyc_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // advance one clock edge and settle at the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_phase(input string tag, input logic cr, input logic ce,
                               input logic bz, input logic dn);
        check({tag, ".core_reset"}, {31'd0, core_reset}, {31'd0, cr});
        check({tag, ".core_en"},    {31'd0, core_en},    {31'd0, ce});
        check({tag, ".busy"},       {31'd0, busy},       {31'd0, bz});
        check({tag, ".done"},       {31'd0, done},       {31'd0, dn});
    endtask

    // Entered at the falling edge of the CLR cycle; leaves at the falling
    // edge of the first FIN cycle with req high.
    task automatic run_body(input int halt_at, input int pc_at, input bit glitch);
        int  n;
        bit  to_exp;
        n = MAXC;
        if (halt_at > 0 && halt_at < n) n = halt_at;
        if (pc_at > 0 && pc_at < n) n = pc_at;
        to_exp = (n == MAXC) && (halt_at != MAXC) && (pc_at != MAXC);

        check_phase("clr", 1'b1, 1'b0, 1'b1, 1'b0);
        check("clr.cyc_cnt", {16'd0, cyc_cnt}, 32'd0);
        for (int k = 1; k <= n; k++) begin
            tick();
            halt_i   = (k == halt_at);
            prog_ctr = (k == pc_at) ? D'(ENDPC) : D'($urandom_range(0, ENDPC - 1));
            if (glitch && k < n) req = 1'($urandom_range(0, 1));
            else                 req = 1'b1;
            check_phase($sformatf("run%0d", k), 1'b0, 1'b1, 1'b1, 1'b0);
            check($sformatf("run%0d.cyc_cnt", k), {16'd0, cyc_cnt}, 32'(k - 1));
        end
        for (int d = 1; d <= DRAIN; d++) begin
            tick();
            halt_i   = 1'b0;
            prog_ctr = D'($urandom_range(0, ENDPC - 1));
            check_phase($sformatf("drn%0d", d), 1'b0, 1'b0, 1'b1, 1'b0);
            check($sformatf("drn%0d.cyc_cnt", d), {16'd0, cyc_cnt}, 32'(n));
        end
        tick();
        check_phase("fin", 1'b1, 1'b0, 1'b0, 1'b1);
        check("fin.cyc_cnt", {16'd0, cyc_cnt}, 32'(n));
        check("fin.timeout", {31'd0, timeout}, {31'd0, to_exp});
        $display("run halt_at=%0d pc_at=%0d glitch=%0d -> cyc_cnt=%0d timeout=%0d (expect %0d/%0d)",
                 halt_at, pc_at, glitch, cyc_cnt, timeout, n, to_exp);
    endtask

    // from IDLE with req low: raise req and run to FIN
    task automatic start_run(input int halt_at, input int pc_at, input bit glitch);
        req = 1'b1;
        tick();
        run_body(halt_at, pc_at, glitch);
    endtask

    // from FIN with req high: drop req and return to IDLE
    task automatic finish_run();
        logic [CW-1:0] held;
        held = cyc_cnt;
        req = 1'b0;
        tick();
        check_phase("fin_hold", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_phase("idle_ret", 1'b1, 1'b0, 1'b0, 1'b0);
        check("idle_ret.cyc_cnt", {16'd0, cyc_cnt}, {16'd0, held});
    endtask

    initial begin
        reset    = 1'b1;
        req      = 1'b0;
        halt_i   = 1'b0;
        prog_ctr = '0;
        tick();
        tick();
        check_phase("rst", 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst.timeout", {31'd0, timeout}, 32'd0);
        check("rst.cyc_cnt", {16'd0, cyc_cnt}, 32'd0);
        reset = 1'b0;
        tick();
        check_phase("idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // reset asserted during RUN cycle 5
        req = 1'b1;
        tick();
        check_phase("mr.clr", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            prog_ctr = D'($urandom_range(0, ENDPC - 1));
            check($sformatf("mr.run%0d.cyc_cnt", k), {16'd0, cyc_cnt}, 32'(k - 1));
        end
        reset = 1'b1;
        req   = 1'b0;
        tick();
        check_phase("mr.rst", 1'b1, 1'b0, 1'b0, 1'b0);
        check("mr.rst.cyc_cnt", {16'd0, cyc_cnt}, 32'd0);
        check("mr.rst.timeout", {31'd0, timeout}, 32'd0);
        $display("reset mid-run -> core_reset=%0d done=%0d cyc_cnt=%0d", core_reset, done, cyc_cnt);
        reset = 1'b0;
        tick();
        check_phase("mr.idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // basic halt in cycle 7
        start_run(7, 0, 1'b0);
        finish_run();
        // cycle limit reached
        start_run(0, 0, 1'b0);
        finish_run();
        // halt coincides with the limit cycle
        start_run(MAXC, 0, 1'b0);
        finish_run();
        // end-of-program PC in cycle 3
        start_run(0, 3, 1'b0);

        // handshake: req held high keeps FIN, one low cycle then a new rise restarts
        for (int i = 0; i < 5; i++) begin
            tick();
            check_phase("hs.hold", 1'b1, 1'b0, 1'b0, 1'b1);
            check("hs.hold.cyc_cnt", {16'd0, cyc_cnt}, 32'd3);
        end
        req = 1'b0;
        tick();
        check_phase("hs.low", 1'b1, 1'b0, 1'b0, 1'b1);
        req = 1'b1;
        tick();
        check_phase("hs.idle", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        $display("handshake restart -> busy=%0d cyc_cnt=%0d", busy, cyc_cnt);
        run_body(12, 0, 1'b0);
        finish_run();

        // randomized runs with req glitching during RUN
        for (int i = 0; i < 10; i++) begin
            start_run(int'($urandom_range(0, MAXC + 5)), int'($urandom_range(0, MAXC + 5)), 1'b1);
            finish_run();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
